// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Pipelined carry-lookahead adder. Each pipeline stage resolves one 4-bit
//   CLA group; the group carry-out is registered and feeds the next stage.
//   Every stage carries the full operand and partial-sum words, so later
//   operand nibbles are naturally delayed and all sum nibbles of one
//   operation leave the last stage together. A single global enable stalls
//   the whole pipeline when the output is valid but not accepted.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = pipeline enable)
//   in_a, in_b          WIDTH-bit operands
//   in_carry            carry-in
//   out_valid/out_ready output handshake
//   out_sum             (in_a + in_b + in_carry) mod 2^WIDTH
//   out_carry           carry out of bit WIDTH-1
//   out_ovf             signed overflow (carry into MSB ^ carry out)
//   PG, GG              block propagate / generate (GG ignores in_carry)
//
// Parameters
//   WIDTH               operand width, multiple of 4, >= 4

module pipelined_cla_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             PG,
   output logic             GG
);

   localparam int NGRP = WIDTH / 4;

   // stage registers: index k holds the result after group k
   logic [WIDTH-1:0] a_q [NGRP];
   logic [WIDTH-1:0] b_q [NGRP];
   logic [WIDTH-1:0] s_q [NGRP];
   logic [NGRP-1:0]  v_q;
   logic [NGRP-1:0]  c_q;
   logic [NGRP-1:0]  pg_q;
   logic [NGRP-1:0]  gg_q;
   logic             ovf_q;

   // stage inputs: stage 0 reads the ports, stage k reads register k-1
   logic [WIDTH-1:0] sa [NGRP];
   logic [WIDTH-1:0] sb [NGRP];
   logic [WIDTH-1:0] ss [NGRP];
   logic [NGRP-1:0]  sv;
   logic [NGRP-1:0]  sc;
   logic [NGRP-1:0]  spg;
   logic [NGRP-1:0]  sgg;

   // stage results
   logic [WIDTH-1:0] ns [NGRP];
   logic [NGRP-1:0]  nc;
   logic [NGRP-1:0]  npg;
   logic [NGRP-1:0]  ngg;
   logic             novf;

   logic             en;

   assign en        = !v_q[NGRP-1] | out_ready;
   assign in_ready  = en;
   assign out_valid = v_q[NGRP-1];
   assign out_sum   = s_q[NGRP-1];
   assign out_carry = c_q[NGRP-1];
   assign out_ovf   = ovf_q;
   assign PG        = pg_q[NGRP-1];
   assign GG        = gg_q[NGRP-1];

   always_comb begin
      sa[0]  = in_a;
      sb[0]  = in_b;
      ss[0]  = '0;
      sv[0]  = in_valid;
      sc[0]  = in_carry;
      // identity values so stage 0 block PG/GG equal its own group P/G
      spg[0] = 1'b1;
      sgg[0] = 1'b0;
      for (int k = 1; k < NGRP; k++) begin
         sa[k]  = a_q[k-1];
         sb[k]  = b_q[k-1];
         ss[k]  = s_q[k-1];
         sv[k]  = v_q[k-1];
         sc[k]  = c_q[k-1];
         spg[k] = pg_q[k-1];
         sgg[k] = gg_q[k-1];
      end
   end

   always_comb begin
      logic [3:0] p;
      logic [3:0] g;
      logic [3:0] c;
      logic       grp_p;
      logic       grp_g;
      p     = '0;
      g     = '0;
      c     = '0;
      grp_p = 1'b0;
      grp_g = 1'b0;
      novf  = 1'b0;
      for (int k = 0; k < NGRP; k++) begin
         p     = sa[k][4*k +: 4] ^ sb[k][4*k +: 4];
         g     = sa[k][4*k +: 4] & sb[k][4*k +: 4];
         c[0]  = sc[k];
         c[1]  = g[0] | (p[0] & c[0]);
         c[2]  = g[1] | (p[1] & g[0]) | (&p[1:0] & c[0]);
         c[3]  = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & c[0]);
         grp_g = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]);
         grp_p = &p;
         nc[k]  = grp_g | (grp_p & c[0]);
         ns[k]  = ss[k];
         ns[k][4*k +: 4] = p ^ c;
         npg[k] = spg[k] & grp_p;
         ngg[k] = grp_g | (grp_p & sgg[k]);
         // c[3] of the top group is the carry into the MSB
         if (k == NGRP-1) begin
            novf = c[3] ^ nc[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q   <= '0;
         c_q   <= '0;
         pg_q  <= '0;
         gg_q  <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < NGRP; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else if (en) begin
         v_q <= sv;
         for (int k = 0; k < NGRP; k++) begin
            // the output stage keeps its last result when a bubble arrives
            if (k < NGRP-1 || sv[k]) begin
               a_q[k]  <= sa[k];
               b_q[k]  <= sb[k];
               s_q[k]  <= ns[k];
               c_q[k]  <= nc[k];
               pg_q[k] <= npg[k];
               gg_q[k] <= ngg[k];
            end
         end
         if (sv[NGRP-1]) begin
            ovf_q <= novf;
         end
      end
   end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

   typedef struct {
      logic [63:0] sum;
      logic        co, ovf, pg, gg;
   } res_t;

   typedef struct {
      logic        ov, ir;
      logic [63:0] sum;
      logic        co, ovf, pg, gg;
   } out_t;

   typedef struct {
      logic [15:0] a, b;
      logic        ci;
      logic [15:0] sum;
      logic        co, ovf, pg, gg;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_out [4] = '{0, 0, 0, 0};
   int   wid   [4] = '{16, 4, 8, 32};
   res_t exp_q [4][$];

   // DUT index 0: WIDTH=16
   logic        d16_iv, d16_ir, d16_ov, d16_ordy, d16_ci, d16_co, d16_ovf, d16_pg, d16_gg;
   logic [15:0] d16_a, d16_b, d16_sum;
   // DUT index 1: WIDTH=4
   logic        d4_iv, d4_ir, d4_ov, d4_ordy, d4_ci, d4_co, d4_ovf, d4_pg, d4_gg;
   logic [3:0]  d4_a, d4_b, d4_sum;
   // DUT index 2: WIDTH=8
   logic        d8_iv, d8_ir, d8_ov, d8_ordy, d8_ci, d8_co, d8_ovf, d8_pg, d8_gg;
   logic [7:0]  d8_a, d8_b, d8_sum;
   // DUT index 3: WIDTH=32
   logic        d32_iv, d32_ir, d32_ov, d32_ordy, d32_ci, d32_co, d32_ovf, d32_pg, d32_gg;
   logic [31:0] d32_a, d32_b, d32_sum;

   pipelined_cla_adder #(.WIDTH(16)) u_d16 (
      .clk(clk), .rst(rst), .in_valid(d16_iv), .in_ready(d16_ir), .in_a(d16_a), .in_b(d16_b),
      .in_carry(d16_ci), .out_valid(d16_ov), .out_ready(d16_ordy), .out_sum(d16_sum),
      .out_carry(d16_co), .out_ovf(d16_ovf), .PG(d16_pg), .GG(d16_gg));

   pipelined_cla_adder #(.WIDTH(4)) u_d4 (
      .clk(clk), .rst(rst), .in_valid(d4_iv), .in_ready(d4_ir), .in_a(d4_a), .in_b(d4_b),
      .in_carry(d4_ci), .out_valid(d4_ov), .out_ready(d4_ordy), .out_sum(d4_sum),
      .out_carry(d4_co), .out_ovf(d4_ovf), .PG(d4_pg), .GG(d4_gg));

   pipelined_cla_adder #(.WIDTH(8)) u_d8 (
      .clk(clk), .rst(rst), .in_valid(d8_iv), .in_ready(d8_ir), .in_a(d8_a), .in_b(d8_b),
      .in_carry(d8_ci), .out_valid(d8_ov), .out_ready(d8_ordy), .out_sum(d8_sum),
      .out_carry(d8_co), .out_ovf(d8_ovf), .PG(d8_pg), .GG(d8_gg));

   pipelined_cla_adder #(.WIDTH(32)) u_d32 (
      .clk(clk), .rst(rst), .in_valid(d32_iv), .in_ready(d32_ir), .in_a(d32_a), .in_b(d32_b),
      .in_carry(d32_ci), .out_valid(d32_ov), .out_ready(d32_ordy), .out_sum(d32_sum),
      .out_carry(d32_co), .out_ovf(d32_ovf), .PG(d32_pg), .GG(d32_gg));

   // Behavioural reference: plain wide arithmetic on masked operands.
   function automatic res_t model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                  input logic ci);
      res_t        r;
      logic [63:0] mask, a, b;
      logic [64:0] full, nocin;
      mask  = (64'd1 << w) - 64'd1;
      a     = a_in & mask;
      b     = b_in & mask;
      full  = {1'b0, a} + {1'b0, b} + {64'd0, ci};
      nocin = {1'b0, a} + {1'b0, b};
      r.sum = full[63:0] & mask;
      r.co  = full[w];
      r.ovf = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
      r.pg  = ((a ^ b) & mask) == mask;
      r.gg  = nocin[w];
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic set_in(input int d, input logic iv, input logic [63:0] a, input logic [63:0] b,
                         input logic ci, input logic ordy);
      case (d)
         0: begin d16_iv = iv; d16_a = a[15:0]; d16_b = b[15:0]; d16_ci = ci; d16_ordy = ordy; end
         1: begin d4_iv  = iv; d4_a  = a[3:0];  d4_b  = b[3:0];  d4_ci  = ci; d4_ordy  = ordy; end
         2: begin d8_iv  = iv; d8_a  = a[7:0];  d8_b  = b[7:0];  d8_ci  = ci; d8_ordy  = ordy; end
         default: begin d32_iv = iv; d32_a = a[31:0]; d32_b = b[31:0]; d32_ci = ci; d32_ordy = ordy; end
      endcase
   endtask

   function automatic out_t get_out(input int d);
      out_t o;
      case (d)
         0: o = '{d16_ov, d16_ir, {48'd0, d16_sum}, d16_co, d16_ovf, d16_pg, d16_gg};
         1: o = '{d4_ov,  d4_ir,  {60'd0, d4_sum},  d4_co,  d4_ovf,  d4_pg,  d4_gg};
         2: o = '{d8_ov,  d8_ir,  {56'd0, d8_sum},  d8_co,  d8_ovf,  d8_pg,  d8_gg};
         default: o = '{d32_ov, d32_ir, {32'd0, d32_sum}, d32_co, d32_ovf, d32_pg, d32_gg};
      endcase
      return o;
   endfunction

   function automatic logic [3:0] flags_o(input out_t o);
      return {o.co, o.ovf, o.pg, o.gg};
   endfunction

   function automatic logic [3:0] flags_r(input res_t r);
      return {r.co, r.ovf, r.pg, r.gg};
   endfunction

   // One clock cycle: drive at negedge, sample 1ns later, score transfers
   // that will happen at the following posedge.
   task automatic cycle(input int d, input logic iv, input logic [63:0] a, input logic [63:0] b,
                        input logic ci, input logic ordy, output out_t o, output logic acc);
      res_t r;
      @(negedge clk);
      set_in(d, iv, a, b, ci, ordy);
      #1;
      o   = get_out(d);
      acc = iv && o.ir;
      if (o.ov && ordy) begin
         chk($sformatf("result expected d%0d", d), 64'(exp_q[d].size() != 0), 64'd1);
         if (exp_q[d].size() != 0) begin
            r = exp_q[d].pop_front();
            chk($sformatf("sum d%0d", d), o.sum, r.sum);
            chk($sformatf("flags d%0d", d), 64'(flags_o(o)), 64'(flags_r(r)));
            n_out[d]++;
         end
      end
      if (acc) exp_q[d].push_back(model(wid[d], a, b, ci));
   endtask

   // Single op into an empty pipeline; measures edges until out_valid.
   task automatic lat_test(input int d, input logic [63:0] a, input logic [63:0] b, input logic ci,
                           input int exp_lat, input res_t exp);
      out_t o;
      int   lat;
      @(negedge clk);
      set_in(d, 1'b1, a, b, ci, 1'b1);
      #1;
      o = get_out(d);
      chk($sformatf("lat in_ready d%0d", d), 64'(o.ir), 64'd1);
      @(negedge clk);
      set_in(d, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
      #1;
      o   = get_out(d);
      lat = 1;
      while (!o.ov && lat < 20) begin
         @(negedge clk);
         #1;
         o = get_out(d);
         lat++;
      end
      chk($sformatf("latency d%0d", d), 64'(lat), 64'(exp_lat));
      chk($sformatf("lat sum d%0d", d), o.sum, exp.sum);
      chk($sformatf("lat flags d%0d", d), 64'(flags_o(o)), 64'(flags_r(exp)));
   endtask

   task automatic drain(input int d);
      out_t o;
      logic acc;
      for (int i = 0; i < 20; i++) cycle(d, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, o, acc);
      chk($sformatf("drained d%0d", d), 64'(exp_q[d].size()), 64'd0);
   endtask

   // Random valid/ready stream; exhaustive walks {cin, b, a} by op index.
   task automatic rand_run(input int d, input int n, input logic exhaustive);
      out_t        o;
      logic        acc, iv, ordy, ci;
      logic [63:0] a, b, idx;
      int          sent, base, cyc;
      sent = 0;
      cyc  = 0;
      base = n_out[d];
      while (sent < n && cyc < 40 * n) begin
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         if (exhaustive) begin
            idx = 64'(sent);
            a   = {60'd0, idx[3:0]};
            b   = {60'd0, idx[7:4]};
            ci  = idx[8];
         end else begin
            a  = {$urandom(), $urandom()};
            b  = {$urandom(), $urandom()};
            ci = 1'($urandom_range(0, 1));
         end
         cycle(d, iv, a, b, ci, ordy, o, acc);
         if (acc) sent++;
         cyc++;
      end
      chk($sformatf("ops sent d%0d", d), 64'(sent), 64'(n));
      drain(d);
      chk($sformatf("result count d%0d", d), 64'(n_out[d] - base), 64'(n));
   endtask

   initial begin
      vec_t        vt [8];
      out_t        o, po;
      logic        acc, prev_stall, ordy_c;
      logic [63:0] sa [8];
      logic [63:0] sb [8];
      logic [63:0] ra, rb;
      int          k, base;

      vt[0] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
      vt[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[5] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[6] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1};

      for (int d = 0; d < 4; d++) set_in(d, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      o = get_out(0);
      chk("reset out_valid", 64'(o.ov), 64'd0);
      chk("reset out_sum", o.sum, 64'd0);
      chk("reset flags", 64'(flags_o(o)), 64'd0);
      chk("reset in_ready", 64'(o.ir), 64'd1);
      for (int d = 1; d < 4; d++) chk($sformatf("reset out_valid d%0d", d), 64'(get_out(d).ov), 64'd0);

      // directed vectors through an empty 16-bit pipeline
      for (int i = 0; i < 8; i++) begin
         lat_test(0, {48'd0, vt[i].a}, {48'd0, vt[i].b}, vt[i].ci, 4,
                  '{{48'd0, vt[i].sum}, vt[i].co, vt[i].ovf, vt[i].pg, vt[i].gg});
         drain(0);
      end

      // latency of the other widths
      lat_test(1, 64'h9, 64'h8, 1'b1, 1, model(4, 64'h9, 64'h8, 1'b1));
      drain(1);
      lat_test(2, 64'h7F, 64'h01, 1'b0, 2, model(8, 64'h7F, 64'h01, 1'b0));
      drain(2);
      ra = {32'd0, $urandom()};
      rb = {32'd0, $urandom()};
      lat_test(3, ra, rb, 1'b1, 8, model(32, ra, rb, 1'b1));
      drain(3);

      // 8 back-to-back ops, downstream stalls in cycles 5..8
      for (int i = 0; i < 8; i++) begin
         sa[i] = {48'd0, 16'($urandom())};
         sb[i] = {48'd0, 16'($urandom())};
      end
      base       = n_out[0];
      k          = 0;
      prev_stall = 1'b0;
      po         = get_out(0);
      for (int c = 1; c <= 20; c++) begin
         ordy_c = !(c >= 5 && c <= 8);
         cycle(0, k < 8, sa[k % 8], sb[k % 8], 1'(k % 2), ordy_c, o, acc);
         if (prev_stall) begin
            chk("stall hold valid", 64'(o.ov), 64'(po.ov));
            chk("stall hold sum", o.sum, po.sum);
            chk("stall hold flags", 64'(flags_o(o)), 64'(flags_o(po)));
         end
         if (!ordy_c && o.ov) chk("stall in_ready", 64'(o.ir), 64'd0);
         prev_stall = o.ov && !ordy_c;
         po         = o;
         if (acc) k++;
      end
      chk("stall ops accepted", 64'(k), 64'd8);
      chk("stall results", 64'(n_out[0] - base), 64'd8);
      drain(0);

      // reset with three operations in flight
      for (int i = 0; i < 3; i++)
         cycle(0, 1'b1, {32'd0, $urandom()}, {32'd0, $urandom()}, 1'b1, 1'b1, o, acc);
      @(negedge clk);
      rst = 1'b1;
      set_in(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      o = get_out(0);
      chk("midreset out_valid", 64'(o.ov), 64'd0);
      chk("midreset out_sum", o.sum, 64'd0);
      chk("midreset flags", 64'(flags_o(o)), 64'd0);
      chk("midreset in_ready", 64'(o.ir), 64'd1);
      exp_q[0].delete();
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, o, acc);
         chk("no stale out_valid", 64'(o.ov), 64'd0);
      end
      lat_test(0, 64'h1111, 64'h2222, 1'b1, 4, model(16, 64'h1111, 64'h2222, 1'b1));
      drain(0);

      rand_run(0, 2000, 1'b0);
      rand_run(1, 512, 1'b1);
      rand_run(2, 3000, 1'b0);
      rand_run(3, 10000, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
